// File: rtl/seq_detect_moore.sv
// Moore serial sequence detector with loadable pattern, overlap control and fill tracking.
// Optional match counter is enabled by defining SEQ_DETECT_COUNT_EN.
module seq_detect_moore #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           sin_i,
    input  logic                           pat_load_i,
    input  logic [WIDTH-1:0]               pattern_i,
    input  logic                           overlap_i,
    output logic                           sout_o,
    output logic [$clog2(WIDTH+1)-1:0]     fill_o,
    output logic [CNT_W-1:0]               match_cnt_o
);

    localparam int FW = $clog2(WIDTH+1);
    localparam logic [FW-1:0] FULL = FW'(WIDTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2,
        S_HIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [WIDTH-1:0]  hist_q, hist_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     fill_base;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    // Leaving S_HIT without overlap discards history, so a bit accepted
    // in that same cycle starts counting from an empty history.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        fill_base = fill_q;
        if (state_q == S_HIT && !overlap_i) begin
            fill_base = '0;
        end
        if (pat_load_i) begin
            pat_d   = pattern_i;
            fill_d  = '0;
            state_d = S_EMPTY;
        end else if (en_i) begin
            hist_d = {hist_q[WIDTH-2:0], sin_i};
            fill_d = (fill_base == FULL) ? FULL : fill_base + FW'(1);
            if (fill_d == FULL && hist_d == pat_q) begin
                state_d = S_HIT;
            end else if (fill_d == FULL) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_FILL;
            end
        end else if (state_q == S_HIT) begin
            if (overlap_i) begin
                state_d = S_ARMED;
                fill_d  = FULL;
            end else begin
                state_d = S_EMPTY;
                fill_d  = '0;
            end
        end
    end

    assign sout_o = (state_q == S_HIT);
    assign fill_o = fill_q;

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Every match drives state_d to S_HIT, including back-to-back matches.
    always_comb begin
        cnt_d = cnt_q;
        if (pat_load_i) begin
            cnt_d = '0;
        end else if (state_d == S_HIT && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt_o = cnt_q;
`else
    assign match_cnt_o = '0;
`endif

endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 Parameter WIDTH, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match counter width; legal range 1..16.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  serial-bit accept strobe; sin sampled only when en=1.
REQ-006 sin  input  1  serial data bit.
REQ-007 pat_load  input  1  load strobe; captures pattern and restarts detection.
REQ-008 pattern  input  WIDTH  target sequence; bit WIDTH-1 is the oldest bit, bit 0 the newest bit.
REQ-009 overlap  input  1  1 = overlapping matches allowed; 0 = history discarded after each match.
REQ-010 sout  output  1  match indication, Moore output decoded from state only.
REQ-011 fill  output  clog2(WIDTH+1)  number of valid history bits, 0..WIDTH.
REQ-012 match_cnt  output  CNT_W  number of matches since reset or last pat_load.

Function
REQ-013 Internal registers SHALL be: pat_reg (WIDTH), hist (WIDTH shift register), fill counter, 2-bit state, match_cnt.
REQ-014 States SHALL be S_EMPTY (fill=0), S_FILL (0<fill<WIDTH), S_ARMED (fill=WIDTH, no match), S_HIT (last accepted bit completed a match).
REQ-015 sout SHALL equal 1 exactly when state=S_HIT; no combinational path from any input to sout.
REQ-016 Accepted bit (en=1, pat_load=0): hist <= {hist[WIDTH-2:0], sin}; fill <= min(fill+1, WIDTH).
REQ-017 Match SHALL be declared when the post-shift fill equals WIDTH and the post-shift hist equals pat_reg; next state S_HIT.
REQ-018 Accepted bit without match: next state S_FILL if post-shift fill<WIDTH, else S_ARMED.
REQ-019 sout SHALL be high for exactly one Clock period, starting at the edge that accepts the completing bit.
REQ-020 From S_HIT with en=0: overlap=1 -> S_ARMED (fill stays WIDTH); overlap=0 -> S_EMPTY (fill=0).
REQ-021 From S_HIT with en=1: overlap=1 -> shift continues from fill=WIDTH; overlap=0 -> fill restarts at 0, so the accepted bit yields fill=1.
REQ-022 With en=0 and pat_load=0, every state other than S_HIT SHALL hold, and hist and fill SHALL hold.
REQ-023 pat_load=1 SHALL take priority over en: pat_reg <= pattern; fill <= 0; state <= S_EMPTY; match_cnt <= 0; sin ignored that cycle.
REQ-024 match_cnt SHALL increment by 1 on each entry to S_HIT and saturate at 2^CNT_W-1; it SHALL NOT wrap.
REQ-025 overlap SHALL be sampled each cycle; a change takes effect on the next transition out of S_HIT.

Reset
REQ-026 Reset=1 SHALL asynchronously force: state=S_EMPTY, hist=0, fill=0, pat_reg=0, match_cnt=0, sout=0.
REQ-027 Reset asserted mid-sequence SHALL discard partial history; after release, detection SHALL require WIDTH fresh accepted bits.

Configuration
REQ-028 Macro SEQ_DETECT_COUNT_EN defined: match_cnt SHALL be implemented per REQ-024.
REQ-029 Macro SEQ_DETECT_COUNT_EN undefined: the counter register SHALL be omitted, and match_cnt SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification (WIDTH=3, CNT_W=2, pattern 3'b101 loaded via pat_load)
REQ-030 overlap=1, en=1, sin 1,0,1,0,1 -> sout high after the 3rd and 5th bits; match_cnt=2 (COUNT_EN).
REQ-031 overlap=0, same stimulus -> sout high only after the 3rd bit; fill=2 after the 5th bit; match_cnt=1.
REQ-032 Bits 1,0, then en=0 for 4 cycles, then bit 1 -> sout low during the gap; single pulse after the final bit; fill stays 2 during the gap.
REQ-033 Bits 1,0, then Reset pulse, then 1 -> no match; fill=1; state S_FILL.
REQ-034 overlap=1, sin 1,0,1,0,1,0,1,0,1,0,1 (5 matches) -> match_cnt saturates at 3; a pat_load pulse then clears match_cnt and fill to 0.
REQ-035 pat_load and en=1 in the same cycle -> pattern captured; sin ignored; fill=0; sout=0 next cycle.
